// File: rtl/vga_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// vga_cfg_ctrl
//
// Register-file front end for the VGA pixel path. Accepts decoded
// (address, data, valid) entries from the UART frame decoder, writes 4-bit
// fields into a shadow register set, and transfers the shadow set to the
// active configuration either immediately or at the next frame boundary.
// The timing/pixel generator therefore never sees a half-updated
// configuration in the middle of a frame.
//
// Build option:
//   VGA_CFG_AUTO_COMMIT_EN - when defined, every accepted shadow write
//                            (addresses 0-7) and LOAD_DEFAULTS also request
//                            a frame-boundary commit.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   address    in   [3:0] decoded register address
//   data       in   [3:0] decoded register data
//   valid      in   decoder entry valid (held until ack or decoder timeout)
//   frame_end  in   one-cycle pulse at start of vertical blank
//   ack        out  one-cycle acknowledge to the decoder
//   fg_color   out  [11:0] active foreground {r,g,b}
//   bg_color   out  [11:0] active background {r,g,b}
//   mode       out  [3:0] active display mode
//   scale      out  [3:0] active pixel scale
//   pending    out  frame-boundary commit requested, not yet applied
//   err        out  sticky flag: write to an unmapped address was seen
//
// Address map:
//   0/1/2 fg r/g/b, 3/4/5 bg r/g/b, 6 mode, 7 scale  (shadow writes)
//   8 COMMIT_VSYNC, 9 COMMIT_NOW, 10 CLEAR_ERR, 15 LOAD_DEFAULTS
//   11-14 unmapped (sets err, still acknowledged)
// ---------------------------------------------------------------------------
module vga_cfg_ctrl #(
  parameter logic [11:0] DEF_FG    = 12'hFFF,
  parameter logic [11:0] DEF_BG    = 12'h000,
  parameter logic [3:0]  DEF_MODE  = 4'h0,
  parameter logic [3:0]  DEF_SCALE = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  address,
  input  logic [3:0]  data,
  input  logic        valid,
  input  logic        frame_end,
  output logic        ack,
  output logic [11:0] fg_color,
  output logic [11:0] bg_color,
  output logic [3:0]  mode,
  output logic [3:0]  scale,
  output logic        pending,
  output logic        err
);

`ifdef VGA_CFG_AUTO_COMMIT_EN
  localparam bit AUTO_COMMIT = 1'b1;
`else
  localparam bit AUTO_COMMIT = 1'b0;
`endif

  // Register fields packed as eight nibbles; field n lives at [4n +: 4],
  // so the register address indexes the field directly.
  localparam logic [31:0] DEFAULTS = {
    DEF_SCALE,
    DEF_MODE,
    DEF_BG[3:0], DEF_BG[7:4], DEF_BG[11:8],
    DEF_FG[3:0], DEF_FG[7:4], DEF_FG[11:8]
  };

  localparam logic [3:0] CMD_COMMIT_VSYNC  = 4'd8;
  localparam logic [3:0] CMD_COMMIT_NOW    = 4'd9;
  localparam logic [3:0] CMD_CLEAR_ERR     = 4'd10;
  localparam logic [3:0] CMD_LOAD_DEFAULTS = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_q,   state_d;
  logic        ack_q,     ack_d;
  logic [31:0] shadow_q,  shadow_d;
  logic [31:0] active_q,  active_d;
  logic        pending_q, pending_d;
  logic        err_q,     err_d;

  logic        frame_commit;

  always_comb begin
    state_d      = state_q;
    ack_d        = 1'b0;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    err_d        = err_q;

    // Frame commit is evaluated first and always copies the pre-edge shadow;
    // an entry executed at the same edge may then override pending or
    // active (COMMIT_VSYNC re-arms, COMMIT_NOW copies the same shadow).
    frame_commit = frame_end && pending_q;
    if (frame_commit) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (valid) begin
          ack_d   = 1'b1;
          state_d = HOLD;
          if (address[3] == 1'b0) begin
            shadow_d[{address[2:0], 2'b00} +: 4] = data;
            if (AUTO_COMMIT) begin
              pending_d = 1'b1;
            end
          end else begin
            unique case (address)
              CMD_COMMIT_VSYNC: pending_d = 1'b1;
              CMD_COMMIT_NOW: begin
                active_d  = shadow_q;
                pending_d = 1'b0;
              end
              CMD_CLEAR_ERR: err_d = 1'b0;
              CMD_LOAD_DEFAULTS: begin
                shadow_d = DEFAULTS;
                if (AUTO_COMMIT) begin
                  pending_d = 1'b1;
                end
              end
              default: err_d = 1'b1;
            endcase
          end
        end
      end
      HOLD: begin
        // Wait for the decoder to release valid so one entry executes once.
        if (!valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      shadow_q  <= DEFAULTS;
      active_q  <= DEFAULTS;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign ack      = ack_q;
  assign fg_color = {active_q[3:0],   active_q[7:4],   active_q[11:8]};
  assign bg_color = {active_q[15:12], active_q[19:16], active_q[23:20]};
  assign mode     = active_q[27:24];
  assign scale    = active_q[31:28];
  assign pending  = pending_q;
  assign err      = err_q;

endmodule

// File: tb/tb_vga_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_cfg_ctrl
//
// Directed bench for vga_cfg_ctrl. A small reference model of the shadow
// and active register sets computes the expected output snapshot whenever
// an entry or frame pulse is driven; the snapshot is queued and compared
// when the DUT acknowledges (or after the frame pulse edge).
// Snapshot layout: {fg_color, bg_color, mode, scale, pending, err}.
// ---------------------------------------------------------------------------
module tb_vga_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  address = '0;
  logic [3:0]  data = '0;
  logic        valid = 1'b0;
  logic        frame_end = 1'b0;
  logic        ack;
  logic [11:0] fg_color;
  logic [11:0] bg_color;
  logic [3:0]  mode;
  logic [3:0]  scale;
  logic        pending;
  logic        err;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [33:0] exp_q[$];

  // Reference model state: index n = register address n.
  logic [3:0]  m_sh[8];
  logic [3:0]  m_act[8];
  logic        m_pend;
  logic        m_err;

  vga_cfg_ctrl #(
    .DEF_FG   (12'hFFF),
    .DEF_BG   (12'h000),
    .DEF_MODE (4'h0),
    .DEF_SCALE(4'h1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .data     (data),
    .valid    (valid),
    .frame_end(frame_end),
    .ack      (ack),
    .fg_color (fg_color),
    .bg_color (bg_color),
    .mode     (mode),
    .scale    (scale),
    .pending  (pending),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] def_field(input int unsigned n);
    logic [31:0] d;
    d = 32'h1000_0FFF;
    return d[4*n +: 4];
  endfunction

  task automatic model_reset();
    for (int unsigned i = 0; i < 8; i++) begin
      m_sh[i]  = def_field(i);
      m_act[i] = def_field(i);
    end
    m_pend = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_frame(input logic fe);
    if (fe && m_pend) begin
      for (int unsigned i = 0; i < 8; i++) m_act[i] = m_sh[i];
      m_pend = 1'b0;
    end
  endtask

  task automatic model_exec(input logic [3:0] a, input logic [3:0] d);
    if (a < 4'd8) begin
      m_sh[a[2:0]] = d;
`ifdef VGA_CFG_AUTO_COMMIT_EN
      m_pend = 1'b1;
`endif
    end else if (a == 4'd8) begin
      m_pend = 1'b1;
    end else if (a == 4'd9) begin
      for (int unsigned i = 0; i < 8; i++) m_act[i] = m_sh[i];
      m_pend = 1'b0;
    end else if (a == 4'd10) begin
      m_err = 1'b0;
    end else if (a == 4'd15) begin
      for (int unsigned i = 0; i < 8; i++) m_sh[i] = def_field(i);
`ifdef VGA_CFG_AUTO_COMMIT_EN
      m_pend = 1'b1;
`endif
    end else begin
      m_err = 1'b1;
    end
  endtask

  function automatic logic [33:0] model_snap();
    return {m_act[0], m_act[1], m_act[2], m_act[3], m_act[4], m_act[5],
            m_act[6], m_act[7], m_pend, m_err};
  endfunction

  function automatic logic [33:0] dut_snap();
    return {fg_color, bg_color, mode, scale, pending, err};
  endfunction

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_pop(input string tag);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s observed=%h expected=<queue empty>", tag, dut_snap());
    end else begin
      e = exp_q.pop_front();
      chk(tag, dut_snap(), e);
    end
  endtask

  // One decoder entry: valid held for 'hold' cycles, optional frame_end on
  // the same edge as acceptance. Exactly one ack is required.
  task automatic xact(input string tag, input logic [3:0] a, input logic [3:0] d,
                      input int unsigned hold, input logic fe);
    int unsigned acks;
    acks = 0;
    @(negedge clk);
    address = a; data = d; valid = 1'b1; frame_end = fe;
    model_frame(fe);
    model_exec(a, d);
    exp_q.push_back(model_snap());
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      frame_end = 1'b0;
      if (ack === 1'b1) begin
        acks++;
        if (acks == 1) chk_pop(tag);
      end
    end
    if (acks == 0) void'(exp_q.pop_front());
    chk({tag, "_ackcnt"}, 34'(acks), 34'd1);
    valid = 1'b0;
    @(negedge clk);
    chk({tag, "_acklow"}, 34'(ack), 34'd0);
  endtask

  task automatic frame_pulse(input string tag);
    @(negedge clk);
    frame_end = 1'b1;
    model_frame(1'b1);
    exp_q.push_back(model_snap());
    @(negedge clk);
    frame_end = 1'b0;
    chk_pop(tag);
    chk({tag, "_ack"}, 34'(ack), 34'd0);
  endtask

  initial begin
    int unsigned acks;

    // Reset values
    model_reset();
    #12;
    exp_q.push_back(model_snap());
    chk_pop("reset");
    chk("reset_ack", 34'(ack), 34'd0);
    @(negedge clk);
    rst = 1'b1;

    // Shadow writes stay invisible until COMMIT_NOW
    xact("fg_r", 4'd0, 4'h4, 1, 1'b0);
    xact("fg_g", 4'd1, 4'h5, 1, 1'b0);
    xact("fg_b_hold5", 4'd2, 4'h6, 5, 1'b0);
    xact("commit_now", 4'd9, 4'h0, 1, 1'b0);

    // Frame-boundary commit
    xact("mode_wr", 4'd6, 4'h3, 1, 1'b0);
    xact("vsync_req", 4'd8, 4'h0, 2, 1'b0);
    frame_pulse("frame_commit");
    frame_pulse("frame_idle");

    // Shadow write on the same edge as the frame commit
    xact("scale_2", 4'd7, 4'h2, 1, 1'b0);
    xact("vsync_req2", 4'd8, 4'h0, 1, 1'b0);
    xact("scale_9_fe", 4'd7, 4'h9, 1, 1'b1);
    xact("commit_now2", 4'd9, 4'h0, 1, 1'b0);

    // COMMIT_VSYNC together with a pending frame commit re-arms pending
    xact("mode_5", 4'd6, 4'h5, 1, 1'b0);
    xact("vsync_req3", 4'd8, 4'h0, 1, 1'b0);
    xact("vsync_fe", 4'd8, 4'h0, 1, 1'b1);
    frame_pulse("frame_rearm");

    // COMMIT_NOW together with a pending frame commit
    xact("mode_7", 4'd6, 4'h7, 1, 1'b0);
    xact("vsync_req4", 4'd8, 4'h0, 1, 1'b0);
    xact("now_fe", 4'd9, 4'h0, 1, 1'b1);

    // LOAD_DEFAULTS together with a frame commit
    xact("fg_r_1", 4'd0, 4'h1, 1, 1'b0);
    xact("vsync_req5", 4'd8, 4'h0, 1, 1'b0);
    xact("defaults_fe", 4'd15, 4'h0, 1, 1'b1);
    xact("commit_defaults", 4'd9, 4'h0, 1, 1'b0);

    // Unmapped addresses and CLEAR_ERR
    xact("unmapped12", 4'd12, 4'hA, 1, 1'b0);
    xact("unmapped14", 4'd14, 4'h3, 1, 1'b0);
    xact("clear_err", 4'd10, 4'h0, 1, 1'b0);
    xact("unmapped11", 4'd11, 4'h0, 1, 1'b0);
    xact("clear_err2", 4'd10, 4'h0, 1, 1'b0);

    // Reset while the entry is held in HOLD
    xact("scale_6", 4'd7, 4'h6, 1, 1'b0);
    xact("commit_scale", 4'd9, 4'h0, 1, 1'b0);
    @(negedge clk);
    address = 4'd6; data = 4'h2; valid = 1'b1;
    model_exec(4'd6, 4'h2);
    exp_q.push_back(model_snap());
    @(negedge clk);
    chk("rst_pre_ack", 34'(ack), 34'd1);
    chk_pop("rst_pre");
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    exp_q.push_back(model_snap());
    chk_pop("rst_async");
    chk("rst_async_ack", 34'(ack), 34'd0);
    @(negedge clk);
    rst = 1'b1;
    model_exec(4'd6, 4'h2);
    exp_q.push_back(model_snap());
    acks = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        acks++;
        if (acks == 1) chk_pop("rst_reexec");
      end
    end
    if (acks == 0) void'(exp_q.pop_front());
    chk("rst_reexec_ackcnt", 34'(acks), 34'd1);
    valid = 1'b0;
    @(negedge clk);
    xact("commit_after_rst", 4'd9, 4'h0, 1, 1'b0);

    // bg red write; auto-applies at frame_end only when auto-commit is built
    xact("bg_r_F", 4'd3, 4'hF, 1, 1'b0);
    frame_pulse("frame_auto");
    xact("commit_bg", 4'd9, 4'h0, 1, 1'b0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
